keypad_divider_ctrl: RTL and testbench



---
 rtl/kdc_pkg.sv | 28 ++
 rtl/key_debouncer.sv | 61 ++++++
 rtl/keypad_divider_ctrl.sv | 125 ++++++++++++
 tb/tb_keypad_divider_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kdc_pkg.sv
// kdc_pkg: shared types, default division table and helpers for keypad_divider_ctrl.
//   kdc_state_e   - controller FSM states
//   DEF_DIV_TABLE - 12-TET half-period counts at 50 MHz, C4..D#5, truncated to 16 bits
//   clamp_div()   - maps a zero division factor to 1 so the divider never stalls
package kdc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } kdc_state_e;

    localparam int unsigned DEF_NUM_KEYS = 16;
    localparam int unsigned DEF_DIV_W    = 16;

    // Lower octave entries exceed 16 bits and wrap on truncation.
    localparam logic [DEF_DIV_W-1:0] DEF_DIV_TABLE [DEF_NUM_KEYS] = '{
        16'(95556), 16'(90193), 16'(85131), 16'(80353),
        16'(75843), 16'(71586), 16'(67568), 16'd63776,
        16'd60197,  16'd56818,  16'd53629,  16'd50619,
        16'd47778,  16'd45097,  16'd42566,  16'd40177
    };

    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: two-flop synchroniser followed by a whole-mask debouncer.
// A new mask is accepted into 'stable' only after it has been seen unchanged
// for DEBOUNCE_CYCLES consecutive cycles.
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   keys   in   raw key mask, asynchronous to clk
//   stable out  debounced key mask
module key_debouncer
    import kdc_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] stable
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] cand_q, cand_d;
    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q < CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            // Counter saturates here; stable keeps being refreshed from cand.
            stable_d = cand_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= keys;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/keypad_divider_ctrl.sv
// keypad_divider_ctrl: debounces the keypad, picks the lowest pressed key and
// loads its division factor into the clock divider, holding the divider in
// reset for the load cycle so each note starts phase-clean.
//   clk_i          in   system clock
//   rst_ni         in   synchronous active-low reset
//   keys_i         in   raw key mask (1 = pressed), asynchronous
//   div_factor_o   out  division factor for the divider
//   div_rst_o      out  active-high divider reset
//   gate_o         out  note sounding
//   key_idx_o      out  index of the selected key
//   note_change_o  out  one-cycle pulse when a new note is loaded
module keypad_divider_ctrl
    import kdc_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 16,
    parameter int unsigned DIV_W           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter logic [DIV_W-1:0] DIV_TABLE [NUM_KEYS] = DEF_DIV_TABLE
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_KEYS-1:0]         keys_i,
    output logic [DIV_W-1:0]            div_factor_o,
    output logic                        div_rst_o,
    output logic                        gate_o,
    output logic [$clog2(NUM_KEYS)-1:0] key_idx_o,
    output logic                        note_change_o
);

    localparam int unsigned IdxW = $clog2(NUM_KEYS);

    logic [NUM_KEYS-1:0] stable;
    logic [IdxW-1:0]     sel_idx;
    logic                sel_valid;

    kdc_state_e      state_q, state_d;
    logic [DIV_W-1:0] div_factor_q, div_factor_d;
    logic [IdxW-1:0]  key_idx_q, key_idx_d;
    logic             div_rst_q, div_rst_d;
    logic             gate_q, gate_d;
    logic             note_change_q, note_change_d;

    key_debouncer #(
        .NUM_KEYS       (NUM_KEYS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .keys  (keys_i),
        .stable(stable)
    );

    // Lowest set bit wins: scan downwards so the last hit is the lowest index.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (stable[i]) begin
                sel_idx = IdxW'(i);
            end
        end
    end

    assign sel_valid = |stable;

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        state_d       = state_q;
        div_factor_d  = div_factor_q;
        key_idx_d     = key_idx_q;
        div_rst_d     = 1'b1;
        gate_d        = 1'b0;
        note_change_d = 1'b0;

        unique case (state_q)
            IDLE: if (sel_valid) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN: begin
                if (!sel_valid) begin
                    state_d = IDLE;
                end else if (sel_idx != key_idx_q) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            LOAD: begin
                div_factor_d  = DIV_W'(clamp_div(32'(DIV_TABLE[sel_idx])));
                key_idx_d     = sel_idx;
                note_change_d = 1'b1;
            end
            RUN: begin
                div_rst_d = 1'b0;
                gate_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            div_factor_q  <= DIV_W'(1);
            key_idx_q     <= '0;
            div_rst_q     <= 1'b1;
            gate_q        <= 1'b0;
            note_change_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_factor_q  <= div_factor_d;
            key_idx_q     <= key_idx_d;
            div_rst_q     <= div_rst_d;
            gate_q        <= gate_d;
            note_change_q <= note_change_d;
        end
    end

    assign div_factor_o  = div_factor_q;
    assign key_idx_o     = key_idx_q;
    assign div_rst_o     = div_rst_q;
    assign gate_o        = gate_q;
    assign note_change_o = note_change_q;

endmodule

// File: tb/tb_keypad_divider_ctrl.sv
// Testbench for keypad_divider_ctrl with a short debounce window and a custom
// division table. A behavioural model predicts every output after each edge.
module tb_keypad_divider_ctrl;

    localparam int unsigned NK  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned DEB = 4;
    localparam logic [DW-1:0] TB_TABLE [NK] = '{
        16'd100, 16'd250, 16'd300, 16'd500, 16'd700, 16'd0,   16'd900, 16'd1100,
        16'd1300, 16'd1500, 16'd1700, 16'd1900, 16'd2100, 16'd2300, 16'd2500, 16'd2700
    };

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] keys;
    logic [DW-1:0] div_factor;
    logic          div_rst, gate, note_change;
    logic [3:0]    key_idx;

    int errors = 0;
    int checks = 0;

    keypad_divider_ctrl #(
        .NUM_KEYS       (NK),
        .DIV_W          (DW),
        .DEBOUNCE_CYCLES(DEB),
        .DIV_TABLE      (TB_TABLE)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .keys_i       (keys),
        .div_factor_o (div_factor),
        .div_rst_o    (div_rst),
        .gate_o       (gate),
        .key_idx_o    (key_idx),
        .note_change_o(note_change)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [NK-1:0] hist [DEB+3];  // hist[j] = mask sampled j edges ago
    logic [NK-1:0] m_stable;
    bit            m_sound, m_loaded;
    int            m_key;
    logic [DW-1:0] exp_factor;
    bit            exp_gate, exp_rst, exp_nc;
    logic [3:0]    exp_idx;

    task automatic model_edge(input logic [NK-1:0] k, input logic r);
        int  w;
        bit  same;
        if (!r) begin
            for (int j = 0; j < DEB + 3; j++) hist[j] = '0;
            m_stable = '0; m_sound = 0; m_loaded = 0; m_key = 0;
            exp_factor = 1; exp_gate = 0; exp_rst = 1; exp_nc = 0; exp_idx = 0;
        end else begin
            w = -1;
            for (int i = NK - 1; i >= 0; i--) if (m_stable[i]) w = i;
            exp_nc = 0;
            if (m_loaded) begin
                m_loaded = 0; m_sound = 1; exp_gate = 1; exp_rst = 0;
            end else if (w >= 0 && (!m_sound || w != m_key)) begin
                m_loaded = 1; m_sound = 0; m_key = w;
                exp_factor = (TB_TABLE[w] == 0) ? DW'(1) : TB_TABLE[w];
                exp_nc = 1; exp_gate = 0; exp_rst = 1;
            end else if (w >= 0) begin
                exp_gate = 1; exp_rst = 0;
            end else begin
                m_sound = 0; exp_gate = 0; exp_rst = 1;
            end
            exp_idx = 4'(m_key);
            for (int j = DEB + 2; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = k;
            // A mask accepted once it is seen DEB+1 times in a row at the synchroniser output.
            same = 1;
            for (int j = 3; j <= DEB + 2; j++) if (hist[j] != hist[2]) same = 0;
            if (same) m_stable = hist[2];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(keys, rst_n);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        keys  = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({div_rst, gate, note_change, div_factor, key_idx} !== {1'b1, 1'b0, 1'b0, 16'd1, 4'd0}) begin
                errors++;
                $display("FAIL reset_outputs: got rst=%b gate=%b nc=%b div=%0d idx=%0d required 1 0 0 1 0",
                         div_rst, gate, note_change, div_factor, key_idx);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({div_rst, gate, note_change} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release_idle: got rst=%b gate=%b nc=%b required 1 0 0",
                     div_rst, gate, note_change);
        end
        keys = '0;
        for (int c = 0; c < 15; c++) begin
            tick();
            checks++;
            if ({gate, div_rst, note_change, key_idx, div_factor} !== {exp_gate, exp_rst, exp_nc, exp_idx, exp_factor}) begin
                errors++;
                $display("FAIL reset_settle: got %b %b %b %0d %0d required %b %b %b %0d %0d",
                         gate, div_rst, note_change, key_idx, div_factor,
                         exp_gate, exp_rst, exp_nc, exp_idx, exp_factor);
            end
        end
    endtask

    task automatic test_single_press();
        keys = 16'h0008;
        for (int n = 1; n <= 12; n++) begin
            tick();
            checks++;
            if (note_change !== (n == DEB + 4)) begin
                errors++;
                $display("FAIL single_pulse_timing: cycle %0d got nc=%b required %b", n, note_change, n == DEB + 4);
            end
            if (n == DEB + 4) begin
                checks++;
                if (div_factor !== 16'd500 || key_idx !== 4'd3) begin
                    errors++;
                    $display("FAIL single_load: got div=%0d idx=%0d required 500 3", div_factor, key_idx);
                end
            end
            if (n > DEB + 4) begin
                checks++;
                if (gate !== 1'b1 || div_rst !== 1'b0) begin
                    errors++;
                    $display("FAIL single_run: cycle %0d got gate=%b rst=%b required 1 0", n, gate, div_rst);
                end
            end
            checks++;
            if ({gate, div_rst, note_change, key_idx, div_factor} !== {exp_gate, exp_rst, exp_nc, exp_idx, exp_factor}) begin
                errors++;
                $display("FAIL single_model: got %b %b %b %0d %0d required %b %b %b %0d %0d",
                         gate, div_rst, note_change, key_idx, div_factor,
                         exp_gate, exp_rst, exp_nc, exp_idx, exp_factor);
            end
        end
    endtask

    task automatic test_priority();
        int pulses;
        logic [NK-1:0] masks [3] = '{16'h0088, 16'h008A, 16'h0088};
        logic [3:0]    idxs  [3] = '{4'd3, 4'd1, 4'd3};
        int            npul  [3] = '{0, 1, 1};
        for (int s = 0; s < 3; s++) begin
            keys   = masks[s];
            pulses = 0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (note_change === 1'b1) pulses++;
                checks++;
                if ({gate, div_rst, note_change, key_idx, div_factor} !== {exp_gate, exp_rst, exp_nc, exp_idx, exp_factor}) begin
                    errors++;
                    $display("FAIL priority_model: step %0d got %b %b %b %0d %0d required %b %b %b %0d %0d", s,
                             gate, div_rst, note_change, key_idx, div_factor,
                             exp_gate, exp_rst, exp_nc, exp_idx, exp_factor);
                end
            end
            checks++;
            if (pulses != npul[s] || key_idx !== idxs[s] || div_factor !== TB_TABLE[idxs[s]] || gate !== 1'b1) begin
                errors++;
                $display("FAIL priority_step%0d: got pulses=%0d idx=%0d div=%0d gate=%b required %0d %0d %0d 1",
                         s, pulses, key_idx, div_factor, gate, npul[s], idxs[s], TB_TABLE[idxs[s]]);
            end
        end
    endtask

    task automatic test_zero_clamp();
        keys = 16'h0020;
        for (int c = 0; c < 12; c++) tick();
        checks++;
        if (div_factor !== 16'd1 || key_idx !== 4'd5 || gate !== 1'b1) begin
            errors++;
            $display("FAIL zero_clamp: got div=%0d idx=%0d gate=%b required 1 5 1", div_factor, key_idx, gate);
        end
        keys = '0;
        for (int c = 0; c < 12; c++) tick();
        checks++;
        if (gate !== 1'b0 || div_rst !== 1'b1 || div_factor !== 16'd1 || key_idx !== 4'd5) begin
            errors++;
            $display("FAIL release_idle: got gate=%b rst=%b div=%0d idx=%0d required 0 1 1 5",
                     gate, div_rst, div_factor, key_idx);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        int first;
        for (int c = 0; c < 40; c++) begin
            keys = ((c / 2) % 2 == 0) ? 16'h0008 : 16'h0000;
            tick();
            checks++;
            if (note_change !== 1'b0 || gate !== 1'b0) begin
                errors++;
                $display("FAIL bounce_quiet: cycle %0d got nc=%b gate=%b required 0 0", c, note_change, gate);
            end
        end
        keys   = 16'h0008;
        pulses = 0;
        first  = -1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (note_change === 1'b1) begin
                pulses++;
                if (first < 0) first = n;
            end
            checks++;
            if ({gate, div_rst, note_change, key_idx, div_factor} !== {exp_gate, exp_rst, exp_nc, exp_idx, exp_factor}) begin
                errors++;
                $display("FAIL bounce_model: got %b %b %b %0d %0d required %b %b %b %0d %0d",
                         gate, div_rst, note_change, key_idx, div_factor,
                         exp_gate, exp_rst, exp_nc, exp_idx, exp_factor);
            end
        end
        checks++;
        if (pulses != 1 || first != DEB + 4) begin
            errors++;
            $display("FAIL bounce_load: got pulses=%0d at cycle %0d required 1 at %0d", pulses, first, DEB + 4);
        end
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 60; seg++) begin
            keys = NK'($urandom) & NK'($urandom) & 16'h00FF;
            hold = $urandom_range(1, 10);
            for (int c = 0; c < hold; c++) begin
                tick();
                checks++;
                if ({gate, div_rst, note_change, key_idx, div_factor} !== {exp_gate, exp_rst, exp_nc, exp_idx, exp_factor}) begin
                    errors++;
                    $display("FAIL random_model: seg %0d got %b %b %b %0d %0d required %b %b %b %0d %0d", seg,
                             gate, div_rst, note_change, key_idx, div_factor,
                             exp_gate, exp_rst, exp_nc, exp_idx, exp_factor);
                end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        bit found = 0;
        keys = '0;
        for (int c = 0; c < 15; c++) tick();
        keys = 16'h0010;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (exp_nc) found = 1;
        end
        checks++;
        if (!found || note_change !== 1'b1) begin
            errors++;
            $display("FAIL midload_reach: got nc=%b found=%0d required 1 1", note_change, found);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({div_rst, gate, note_change, div_factor, key_idx} !== {1'b1, 1'b0, 1'b0, 16'd1, 4'd0}) begin
            errors++;
            $display("FAIL midload_reset: got rst=%b gate=%b nc=%b div=%0d idx=%0d required 1 0 0 1 0",
                     div_rst, gate, note_change, div_factor, key_idx);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (gate !== 1'b0 || div_rst !== 1'b1 || note_change !== 1'b0) begin
            errors++;
            $display("FAIL midload_no_run: got gate=%b rst=%b nc=%b required 0 1 0", gate, div_rst, note_change);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        keys  = '0;
        test_reset();
        test_single_press();
        test_priority();
        test_zero_clamp();
        test_bounce();
        test_random();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
